// File: rtl/id_hazard_controller_pkg.sv
// Shared encodings and defaults for the decode-stage hazard controller.
`default_nettype none
package id_hazard_controller_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [4:0]  REG_ZERO           = 5'd0;
   localparam int unsigned DEF_LOAD_BR_STALLS = 2;
   localparam int unsigned DEF_CNT_W          = 32;

endpackage
`default_nettype wire

// File: rtl/id_hazard_controller_hazard_match.sv
// Combinational producer/consumer comparator for the ID-stage source registers.
`default_nettype none
module id_hazard_controller_hazard_match
   import id_hazard_controller_pkg::*;
(
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_reg_write,
   input  logic [4:0] ex_write_reg,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_write_reg,
   output logic       ex_match_rs,
   output logic       ex_match_rt,
   output logic       mem_match_rs,
   output logic       mem_match_rt
);

   // $0 is hardwired, so a write to it can never be a true dependency.
   assign ex_match_rs  = id_uses_rs && ex_reg_write  && (ex_write_reg  == id_rs) && (id_rs != REG_ZERO);
   assign ex_match_rt  = id_uses_rt && ex_reg_write  && (ex_write_reg  == id_rt) && (id_rt != REG_ZERO);
   assign mem_match_rs = id_uses_rs && mem_reg_write && (mem_write_reg == id_rs) && (id_rs != REG_ZERO);
   assign mem_match_rt = id_uses_rt && mem_reg_write && (mem_write_reg == id_rt) && (id_rt != REG_ZERO);

endmodule
`default_nettype wire

// File: rtl/id_hazard_controller.sv
// Decode-stage hazard controller: stall/bubble sequencing, ID forwarding selects and IF flush.
`default_nettype none
module id_hazard_controller
   import id_hazard_controller_pkg::*;
#(
   parameter int unsigned CNT_W          = DEF_CNT_W,
   parameter int unsigned LOAD_BR_STALLS = DEF_LOAD_BR_STALLS
)(
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_Branch,
   input  logic             ID_JumpReg,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_WriteReg,
   input  logic             MEM_RegWrite,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_WriteReg,
   input  logic             BranchOut,
   input  logic             Jump,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             FlushControl,
   output logic             IFFlush,
   output logic             ForwardE,
   output logic             ForwardF,
   output logic             Stalling,
   output logic [CNT_W-1:0] StallCycles
);

   localparam logic [1:0] LOAD_N = 2'(LOAD_BR_STALLS);

   logic ex_match_rs, ex_match_rt, mem_match_rs, mem_match_rt;
   logic ex_match, mem_match, br_use;
   logic [1:0] demand;
   logic stall_now;

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

   id_hazard_controller_hazard_match u_hazard_match (
      .id_uses_rs    (ID_UsesRs),
      .id_uses_rt    (ID_UsesRt),
      .id_rs         (ID_Rs),
      .id_rt         (ID_Rt),
      .ex_reg_write  (EX_RegWrite),
      .ex_write_reg  (EX_WriteReg),
      .mem_reg_write (MEM_RegWrite),
      .mem_write_reg (MEM_WriteReg),
      .ex_match_rs   (ex_match_rs),
      .ex_match_rt   (ex_match_rt),
      .mem_match_rs  (mem_match_rs),
      .mem_match_rt  (mem_match_rt)
   );

   assign ex_match  = ex_match_rs || ex_match_rt;
   assign mem_match = mem_match_rs || mem_match_rt;
   assign br_use    = ID_Branch || ID_JumpReg;

   always_comb begin
      demand = 2'd0;
      if (br_use && ex_match && EX_MemRead)
         demand = LOAD_N;
      else if (br_use && ex_match)
         demand = 2'd1;
      else if (br_use && mem_match && MEM_MemRead)
         demand = 2'd1;
      else if (!br_use && ex_match && EX_MemRead)
         demand = 2'd1;
   end

   // cnt_q holds the stall cycles still owed, including the current STALL cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_now = 1'b0;
      case (state_q)
         RUN: begin
            if (demand != 2'd0) begin
               stall_now = 1'b1;
               if ((demand - 2'd1) != 2'd0) begin
                  state_d = STALL;
                  cnt_d   = demand - 2'd1;
               end
            end
         end
         STALL: begin
            stall_now = 1'b1;
            if (cnt_q <= 2'd1) begin
               state_d = RUN;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_now && !(&stall_cycles_q))
         stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q        <= RUN;
         cnt_q          <= 2'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign PCWrite      = !stall_now;
   assign IFIDWrite    = !stall_now;
   assign FlushControl = stall_now;
   assign Stalling     = stall_now;
   // Forward selects are meaningless while the consumer is being held, so mask them.
   assign ForwardE     = mem_match_rs && !MEM_MemRead && !stall_now;
   assign ForwardF     = mem_match_rt && !MEM_MemRead && !stall_now;
   assign IFFlush      = ((BranchOut && ID_Branch) || Jump) && !stall_now;
   assign StallCycles  = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_controller.sv
// Directed self-checking bench for id_hazard_controller.
`default_nettype none
module tb_id_hazard_controller;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [4:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
   logic       ID_UsesRs, ID_UsesRt, ID_Branch, ID_JumpReg;
   logic       EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, BranchOut, Jump;

   logic        PCWrite, IFIDWrite, FlushControl, IFFlush, ForwardE, ForwardF, Stalling;
   logic [31:0] StallCycles;
   logic        PCWrite4, IFIDWrite4, FlushControl4, IFFlush4, ForwardE4, ForwardF4, Stalling4;
   logic [3:0]  StallCycles4;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   id_hazard_controller dut (
      .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch), .ID_JumpReg(ID_JumpReg),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
      .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
      .BranchOut(BranchOut), .Jump(Jump),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .FlushControl(FlushControl), .IFFlush(IFFlush),
      .ForwardE(ForwardE), .ForwardF(ForwardF), .Stalling(Stalling), .StallCycles(StallCycles)
   );

   id_hazard_controller #(.CNT_W(4)) dut4 (
      .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch), .ID_JumpReg(ID_JumpReg),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
      .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
      .BranchOut(BranchOut), .Jump(Jump),
      .PCWrite(PCWrite4), .IFIDWrite(IFIDWrite4), .FlushControl(FlushControl4), .IFFlush(IFFlush4),
      .ForwardE(ForwardE4), .ForwardF(ForwardF4), .Stalling(Stalling4), .StallCycles(StallCycles4)
   );

   // {PCWrite, IFIDWrite, FlushControl, IFFlush, ForwardE, ForwardF, Stalling}
   function automatic logic [6:0] outs();
      return {PCWrite, IFIDWrite, FlushControl, IFFlush, ForwardE, ForwardF, Stalling};
   endfunction

   task automatic idle();
      ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
      ID_Branch = 1'b0; ID_JumpReg = 1'b0;
      EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
      MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
      BranchOut = 1'b0; Jump = 1'b0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      Reset = 1'b1;
      #3;
      checks++;
      if (outs() !== 7'b1100000) begin
         errors++; $display("FAIL reset_outs: got %b expected %b", outs(), 7'b1100000);
      end
      checks++;
      if (StallCycles !== 32'd0) begin
         errors++; $display("FAIL reset_cnt: got %0d expected 0", StallCycles);
      end
      @(negedge Clk);
      Reset = 1'b0;
      step();
   endtask

   task automatic test_load_branch();
      // lw $8 in EX, beq $8,$9 in ID, branch result asserted while pending
      ID_Branch = 1'b1; ID_Rs = 5'd8; ID_Rt = 5'd9; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd8; BranchOut = 1'b1;
      #3;
      checks++;
      if (outs() !== 7'b0010001) begin
         errors++; $display("FAIL ldbr_stall1: got %b expected %b", outs(), 7'b0010001);
      end
      step();
      EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
      MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd8;
      #3;
      checks++;
      if (outs() !== 7'b0010001) begin
         errors++; $display("FAIL ldbr_stall2: got %b expected %b", outs(), 7'b0010001);
      end
      step();
      MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_WriteReg = 5'd0;
      #3;
      checks++;
      if (outs() !== 7'b1101000) begin
         errors++; $display("FAIL ldbr_resolve: got %b expected %b", outs(), 7'b1101000);
      end
      checks++;
      if (StallCycles !== 32'd2) begin
         errors++; $display("FAIL ldbr_count: got %0d expected 2", StallCycles);
      end
      step();
      idle();
      #3;
      checks++;
      if (outs() !== 7'b1100000) begin
         errors++; $display("FAIL ldbr_after: got %b expected %b", outs(), 7'b1100000);
      end
      step();
   endtask

   task automatic test_alu_branch();
      ID_Branch = 1'b1; ID_Rs = 5'd8; ID_Rt = 5'd0; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
      EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
      #3;
      checks++;
      if (outs() !== 7'b0010001) begin
         errors++; $display("FAIL alubr_stall: got %b expected %b", outs(), 7'b0010001);
      end
      step();
      EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
      MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd8;
      #3;
      checks++;
      if (outs() !== 7'b1100100) begin
         errors++; $display("FAIL alubr_fwd: got %b expected %b", outs(), 7'b1100100);
      end
      checks++;
      if (StallCycles !== 32'd3) begin
         errors++; $display("FAIL alubr_count: got %0d expected 3", StallCycles);
      end
      step();
      idle();
   endtask

   task automatic test_load_use();
      // lw $5 in EX, add $6,$5,$7 in ID; an ALU result for $7 sits in MEM
      ID_Rs = 5'd5; ID_Rt = 5'd7; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd5;
      MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd7;
      #3;
      checks++;
      if (outs() !== 7'b0010001) begin
         errors++; $display("FAIL lduse_stall: got %b expected %b", outs(), 7'b0010001);
      end
      step();
      EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
      MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_WriteReg = 5'd5;
      #3;
      checks++;
      if (outs() !== 7'b1100000) begin
         errors++; $display("FAIL lduse_after: got %b expected %b", outs(), 7'b1100000);
      end
      checks++;
      if (StallCycles !== 32'd4) begin
         errors++; $display("FAIL lduse_count: got %0d expected 4", StallCycles);
      end
      step();
      idle();
   endtask

   task automatic test_zero_reg();
      ID_Branch = 1'b1; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd0;
      MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd0;
      BranchOut = 1'b1;
      #3;
      checks++;
      if (outs() !== 7'b1101000) begin
         errors++; $display("FAIL zero_reg: got %b expected %b", outs(), 7'b1101000);
      end
      step();
      idle();
      #3;
      checks++;
      if (StallCycles !== 32'd4) begin
         errors++; $display("FAIL zero_count: got %0d expected 4", StallCycles);
      end
      step();
   endtask

   task automatic test_jump();
      Jump = 1'b1; ID_Rs = 5'd4; EX_RegWrite = 1'b1; EX_WriteReg = 5'd3;
      #3;
      checks++;
      if (outs() !== 7'b1101000) begin
         errors++; $display("FAIL jump_plain: got %b expected %b", outs(), 7'b1101000);
      end
      step();
      idle();
      Jump = 1'b1; ID_JumpReg = 1'b1; ID_Rs = 5'd9; ID_UsesRs = 1'b1;
      MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd9;
      #3;
      checks++;
      if (outs() !== 7'b1101100) begin
         errors++; $display("FAIL jr_fwd: got %b expected %b", outs(), 7'b1101100);
      end
      step();
      MEM_MemRead = 1'b1;
      #3;
      checks++;
      if (outs() !== 7'b0010001) begin
         errors++; $display("FAIL jr_memload: got %b expected %b", outs(), 7'b0010001);
      end
      step();
      idle();
      #3;
      checks++;
      if (outs() !== 7'b1100000 || StallCycles !== 32'd5) begin
         errors++; $display("FAIL jr_after: got %b/%0d expected %b/5", outs(), StallCycles, 7'b1100000);
      end
      step();
   endtask

   task automatic test_reset_mid_stall();
      ID_Branch = 1'b1; ID_Rs = 5'd8; ID_Rt = 5'd9; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
      EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_WriteReg = 5'd8;
      step();
      EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
      #2;
      checks++;
      if (outs() !== 7'b0010001 || StallCycles !== 32'd6) begin
         errors++; $display("FAIL midrst_pre: got %b/%0d expected %b/6", outs(), StallCycles, 7'b0010001);
      end
      Reset = 1'b1;
      idle();
      #1;
      checks++;
      if (outs() !== 7'b1100000 || StallCycles !== 32'd0) begin
         errors++; $display("FAIL midrst_now: got %b/%0d expected %b/0", outs(), StallCycles, 7'b1100000);
      end
      #2;
      Reset = 1'b0;
      step();
      #3;
      checks++;
      if (outs() !== 7'b1100000) begin
         errors++; $display("FAIL midrst_run1: got %b expected %b", outs(), 7'b1100000);
      end
      step();
      #3;
      checks++;
      if (outs() !== 7'b1100000 || StallCycles !== 32'd0) begin
         errors++; $display("FAIL midrst_run2: got %b/%0d expected %b/0", outs(), StallCycles, 7'b1100000);
      end
      step();
   endtask

   task automatic test_saturation();
      ID_Branch = 1'b1; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
      EX_RegWrite = 1'b1; EX_WriteReg = 5'd8;
      for (int i = 0; i < 20; i++) step();
      idle();
      #3;
      checks++;
      if (StallCycles4 !== 4'hF) begin
         errors++; $display("FAIL sat_cnt4: got %h expected f", StallCycles4);
      end
      checks++;
      if (StallCycles !== 32'd20) begin
         errors++; $display("FAIL sat_cnt32: got %0d expected 20", StallCycles);
      end
      step();
      checks++;
      if (StallCycles4 !== 4'hF || PCWrite4 !== 1'b1) begin
         errors++; $display("FAIL sat_hold: got %h/%b expected f/1", StallCycles4, PCWrite4);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load_branch();
      test_alu_branch();
      test_load_use();
      test_zero_reg();
      test_jump();
      test_reset_mid_stall();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/id_hazard_controller.md
Name: id_hazard_controller

Overview:
- Sequences the decode stage around data hazards that branch comparison and jump-register resolution in ID create.
- Decides when to stall PC and IF/ID and when to inject a bubble via FlushControl.
- Drives the ID-stage forward selects ForwardE/ForwardF and flushes IF on a taken branch or jump.
- Sits beside the decode stage; takes register specifiers from IF/ID, ID/EX and EX/MEM.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter.
- LOAD_BR_STALLS, 2, stall cycles when a branch/jr source is produced by a load currently in EX.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- ID_Rs  in  5  Instruction[25:21] in ID
- ID_Rt  in  5  Instruction[20:16] in ID
- ID_UsesRs  in  1  ID instruction reads rs
- ID_UsesRt  in  1  ID instruction reads rt
- ID_Branch  in  1  Branch from Controller (unflushed decode)
- ID_JumpReg  in  1  ID instruction is jr/jalr (reads rs in ID)
- EX_RegWrite  in  1  ID/EX RegWrite
- EX_MemRead  in  1  ID/EX MemRead
- EX_WriteReg  in  5  ID/EX destination register
- MEM_RegWrite  in  1  EX/MEM RegWrite
- MEM_MemRead  in  1  EX/MEM MemRead
- MEM_WriteReg  in  5  EX/MEM destination register
- BranchOut  in  1  taken-branch result from ID
- Jump  in  1  ID Jump control
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- FlushControl  out  1  zero ID control signals (bubble into EX)
- IFFlush  out  1  clear IF/ID on next edge
- ForwardE  out  1  select ForwardData for rs in ID
- ForwardF  out  1  select ForwardData for rt in ID
- Stalling  out  1  state != RUN or stall being entered
- StallCycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Match rule: matchX(r) = X_RegWrite && X_WriteReg == r && r != 0, gated by ID_UsesRs/ID_UsesRt. Register $0 never matches.
- BrUse = ID_Branch || ID_JumpReg.
- Stall demand in RUN, highest first:
  - BrUse and EX match and EX_MemRead -> LOAD_BR_STALLS cycles.
  - BrUse and EX match, not a load -> 1 cycle.
  - BrUse and MEM match and MEM_MemRead -> 1 cycle.
  - Non-branch and EX match and EX_MemRead -> 1 cycle (load-use).
  - Otherwise 0.
- FSM states RUN, STALL; 2-bit down counter Cnt.
  - RUN, demand n>0: current cycle PCWrite=0, IFIDWrite=0, FlushControl=1. Next state STALL, Cnt=n-1. If n-1 == 0, stay RUN and re-evaluate next cycle.
  - STALL: PCWrite=0, IFIDWrite=0, FlushControl=1, Cnt decrements each cycle. At Cnt==0 go to RUN; demand is re-evaluated combinationally that cycle.
  - Demand recomputed in RUN always converges to 0 after the stall, because the producer has advanced.
- Forwarding is valid only when no stall is asserted:
  - ForwardE = ID_UsesRs && MEM match(rs) && !MEM_MemRead.
  - ForwardF likewise for rt.
  - WB-to-ID needs no forward; the register file writes before read.
- IFFlush = (BranchOut && ID_Branch || Jump) && !stall_now, where stall_now is the current-cycle stall.
  - A branch whose operands are still pending never flushes; it flushes in the first non-stalled cycle.
- Simultaneous events:
  - Stall and taken branch: the stall wins and IFFlush=0.
  - Jump without register dependency never stalls.
- StallCycles increments by 1 on every cycle with PCWrite=0 and saturates at all-ones.
- Reset (async, any state including mid-stall) forces:
  - state RUN, Cnt=0, StallCycles=0.
  - Outputs settle combinationally to PCWrite=1, IFIDWrite=1, FlushControl=0, IFFlush=0, ForwardE=0, ForwardF=0, Stalling=0 (given idle inputs).
- Latency: detection is same-cycle (combinational on inputs); stall continuation is registered.

Decomposition:
- Shared package holds:
  - state encoding RUN=1'b0, STALL=1'b1
  - REG_ZERO=5'd0
  - LOAD_BR_STALLS default
  - CNT_W default
- One natural sub-module: hazard_match, the combinational comparator giving EX/MEM match bits for rs and rt. It is instantiated once; FSM and counter stay in the top.

Test Plan:
- lw $8 in EX, beq $8,$9 in ID.
  - PCWrite=0, IFIDWrite=0, FlushControl=1 for 2 cycles.
  - Then ForwardE=0 and branch resolves; if taken, IFFlush=1 for 1 cycle.
  - StallCycles=2.
- add $8 in EX, beq $8,$0 in ID.
  - 1 stall cycle.
  - Next cycle ForwardE=1 (MEM match), no stall.
- lw $5 in EX, add $6,$5,$7 in ID: 1 stall, FlushControl=1 that cycle; ForwardE stays 0.
- Destination $0 in EX with MemRead, beq $0,$0 in ID: no stall, IFFlush=1 when BranchOut=1.
- Reset asserted mid-way through a 2-cycle stall.
  - Immediately PCWrite=1 and StallCycles=0.
  - After release the FSM is in RUN with no residual stall.
- Counter saturation: preload StallCycles to all-ones via CNT_W=4 build, force 20 stall cycles -> holds 4'hF.
